// File: rtl/chacha_sequencer.sv
// chacha_sequencer: drives the shared byte bus of the four column quarter
// slices. Each block it clears the slices, loads 48 key/counter/nonce bytes
// into rows 1-3, lets the core run ROUNDS column/diagonal steps, then streams
// all 64 state bytes back to the host.
module chacha_sequencer #(
  parameter int ROUNDS      = 20,
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       core_clear,
  output logic       core_hold,
  output logic       core_diag,
  output logic       core_write,
  output logic [5:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata
);

  localparam int RUN_CYCLES = ROUNDS * STEP_CYCLES;
  localparam int STEP_W     = $clog2(RUN_CYCLES + 1);
  localparam int PHASE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [STEP_W-1:0]  RUN_LAST   = STEP_W'(RUN_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STEP_CYCLES - 1);

  // An odd round count would leave the core after a column step, and a zero
  // step length would make the run window empty.
  generate
    if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
      $error("chacha_sequencer: ROUNDS must be even and >= 2");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
      $error("chacha_sequencer: STEP_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         load_cnt_q, load_cnt_d;
  logic [5:0]         rd_cnt_q, rd_cnt_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               diag_q, diag_d;
  logic               done_q, done_d;

  // State and counter registers; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      rd_cnt_q   <= '0;
      step_q     <= '0;
      phase_q    <= '0;
      diag_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      step_q     <= step_d;
      phase_q    <= phase_d;
      diag_q     <= diag_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counter updates and bus strobes for the current phase.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    step_d     = step_q;
    phase_d    = phase_q;
    diag_d     = diag_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_clear = 1'b0;
    core_hold  = 1'b1;
    core_write = 1'b0;
    core_addr  = 6'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        core_clear = 1'b1;
        load_cnt_d = 6'd16;
        state_d    = S_LOAD;
      end

      S_LOAD: begin
        in_ready  = 1'b1;
        core_addr = load_cnt_q;
        if (in_valid) begin
          core_write = 1'b1;
          load_cnt_d = load_cnt_q + 6'd1;
          if (load_cnt_q == 6'd63) begin
            state_d = S_RUN;
            step_d  = '0;
            phase_d = '0;
            diag_d  = 1'b0;
          end
        end
      end

      S_RUN: begin
        core_hold = 1'b0;
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          diag_d  = ~diag_q;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == RUN_LAST) begin
          state_d  = S_DRAIN;
          step_d   = '0;
          rd_cnt_d = 6'd0;
        end
      end

      S_DRAIN: begin
        out_valid = 1'b1;
        core_addr = rd_cnt_q;
        if (out_ready) begin
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q == 6'd63) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign core_diag  = diag_q;
  assign core_wdata = in_data;
  assign out_data   = core_rdata;

endmodule

// File: tb/tb_chacha_sequencer.sv
// tb_chacha_sequencer: runs two sequencers side by side (default 20x1 and a
// short 4x3 configuration) against a count-based block model and a simple
// 64-byte slice memory that stands in for the quarter slices.
module tb_chacha_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] start_v;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic [1:0] in_ready_v, out_valid_v, busy_v, done_v;
  logic [1:0] core_clear_v, core_hold_v, core_diag_v, core_write_v;
  logic [7:0] out_data_v   [2];
  logic [5:0] core_addr_v  [2];
  logic [7:0] core_wdata_v [2];
  logic [7:0] core_rdata_v [2];
  logic [7:0] slice        [2][64];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Block model: position in a block is tracked purely by event counts.
  bit       m_active  [2];
  bit       m_cleared [2];
  int       m_loaded  [2];
  int       m_run     [2];
  int       m_drained [2];
  bit       m_done    [2];
  int       start_cyc [2];
  logic [7:0] exp_mem [2][64];

  // Observed statistics used for the hand-computed literal checks.
  int         first_wr_rel [2];
  int         first_wr_addr[2];
  int         wr_cnt       [2];
  int         run_rel      [2];
  int         run_cnt      [2];
  int         ov_rel       [2];
  int         hs_cnt       [2];
  int         stall_cnt    [2];
  int         clear_abs    [2];
  int         done_abs     [2];
  int         done_rel     [2];
  bit         done_seen    [2];
  logic [11:0] diag_vec    [2];

  function automatic int run_len(input int k);
    return (k == 0) ? 20 : 12;
  endfunction

  function automatic int step_len(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  chacha_sequencer #(.ROUNDS(20), .STEP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .out_data(out_data_v[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .busy(busy_v[0]), .done(done_v[0]),
    .core_clear(core_clear_v[0]), .core_hold(core_hold_v[0]), .core_diag(core_diag_v[0]),
    .core_write(core_write_v[0]), .core_addr(core_addr_v[0]),
    .core_wdata(core_wdata_v[0]), .core_rdata(core_rdata_v[0])
  );

  chacha_sequencer #(.ROUNDS(4), .STEP_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .out_data(out_data_v[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .busy(busy_v[1]), .done(done_v[1]),
    .core_clear(core_clear_v[1]), .core_hold(core_hold_v[1]), .core_diag(core_diag_v[1]),
    .core_write(core_write_v[1]), .core_addr(core_addr_v[1]),
    .core_wdata(core_wdata_v[1]), .core_rdata(core_rdata_v[1])
  );

  assign core_rdata_v[0] = slice[0][core_addr_v[0]];
  assign core_rdata_v[1] = slice[1][core_addr_v[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  // Stand-in slices: start with junk so a missing clear shows up in row 0.
  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) slice[k][i] = 8'hEE;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (core_clear_v[k] === 1'b1)
          for (int i = 0; i < 64; i++) slice[k][i] = 8'h00;
        else if (core_write_v[k] === 1'b1)
          slice[k][core_addr_v[k]] = core_wdata_v[k];
      end
    end
  end

  // Model update on each rising edge from the inputs the DUTs sample.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0; m_cleared[k] = 0; m_loaded[k] = 0;
      m_run[k] = 0; m_drained[k] = 0; m_done[k] = 0; start_cyc[k] = 0;
    end
    forever begin
      @(posedge clk);
      if (rst) chk_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_active[k] = 0; m_cleared[k] = 0; m_loaded[k] = 0;
          m_run[k] = 0; m_drained[k] = 0; m_done[k] = 0;
        end else begin
          m_done[k] = 0;
          if (!m_active[k]) begin
            if (start_v[k]) begin
              m_active[k] = 1; m_cleared[k] = 0; m_loaded[k] = 0;
              m_run[k] = 0; m_drained[k] = 0; start_cyc[k] = cyc;
              for (int i = 0; i < 64; i++) exp_mem[k][i] = 8'h00;
            end
          end else if (!m_cleared[k]) begin
            m_cleared[k] = 1;
          end else if (m_loaded[k] < 48) begin
            if (in_valid) begin
              exp_mem[k][16 + m_loaded[k]] = in_data;
              m_loaded[k]++;
            end
          end else if (m_run[k] < run_len(k)) begin
            m_run[k]++;
          end else if (out_ready) begin
            m_drained[k]++;
            if (m_drained[k] == 64) begin
              m_active[k] = 0;
              m_done[k]   = 1;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          bit ph_clr, ph_ld, ph_run, ph_dr;
          int rel;
          logic [5:0] e_addr;
          ph_clr = m_active[k] && !m_cleared[k];
          ph_ld  = m_active[k] && m_cleared[k] && (m_loaded[k] < 48);
          ph_run = m_active[k] && m_cleared[k] && (m_loaded[k] >= 48) && (m_run[k] < run_len(k));
          ph_dr  = m_active[k] && m_cleared[k] && (m_loaded[k] >= 48) && (m_run[k] >= run_len(k));
          e_addr = ph_ld ? 6'(16 + m_loaded[k]) : (ph_dr ? 6'(m_drained[k]) : 6'd0);
          checkOutput("busy", k, busy_v[k], m_active[k]);
          checkOutput("done", k, done_v[k], m_done[k]);
          checkOutput("core_clear", k, core_clear_v[k], ph_clr);
          checkOutput("in_ready", k, in_ready_v[k], ph_ld);
          checkOutput("core_write", k, core_write_v[k], ph_ld && in_valid);
          checkOutput("core_hold", k, core_hold_v[k], !ph_run);
          checkOutput("core_diag", k, core_diag_v[k],
                      ph_run ? ((m_run[k] / step_len(k)) % 2) : 0);
          checkOutput("out_valid", k, out_valid_v[k], ph_dr);
          checkOutput("core_addr", k, core_addr_v[k], e_addr);
          checkOutput("core_wdata", k, core_wdata_v[k], in_data);
          if (ph_dr)
            checkOutput("out_data", k, out_data_v[k], exp_mem[k][m_drained[k]]);

          rel = cyc - start_cyc[k];
          if (core_write_v[k] === 1'b1) begin
            wr_cnt[k]++;
            if (first_wr_rel[k] < 0) begin
              first_wr_rel[k]  = rel;
              first_wr_addr[k] = int'(core_addr_v[k]);
            end
          end
          if (core_hold_v[k] === 1'b0) begin
            run_cnt[k]++;
            if (run_rel[k] < 0) run_rel[k] = rel;
            diag_vec[k] = {diag_vec[k][10:0], core_diag_v[k]};
          end
          if (out_valid_v[k] === 1'b1) begin
            if (ov_rel[k] < 0) ov_rel[k] = rel;
            if (out_ready) hs_cnt[k]++;
            else if (core_addr_v[k] == 6'd7) stall_cnt[k]++;
          end
          if (core_clear_v[k] === 1'b1) clear_abs[k] = cyc;
          if (done_v[k] === 1'b1) begin
            done_seen[k] = 1;
            done_rel[k]  = rel;
            done_abs[k]  = cyc;
          end
        end
      end
    end
  end

  // Runs one block on DUT k. Entered and left at posedge+2.
  task automatic applyStimulus(input int k, input bit do_start, input bit toggle,
                               input int stall_at, input bit busy_starts, input bit chain);
    int n = 0;
    int stall_left = 5;
    first_wr_rel[k] = -1; first_wr_addr[k] = -1; wr_cnt[k] = 0;
    run_rel[k] = -1; run_cnt[k] = 0; ov_rel[k] = -1; hs_cnt[k] = 0;
    stall_cnt[k] = 0; clear_abs[k] = -1; done_abs[k] = -1; done_rel[k] = -1;
    done_seen[k] = 0; diag_vec[k] = '0;
    if (do_start) begin
      start_v[k] = 1'b1;
      @(posedge clk); #2;
      start_v[k] = 1'b0;
    end
    while (!done_seen[k] && n < 400) begin
      in_valid = toggle ? (n % 2 == 0) : 1'b1;
      in_data  = (toggle ? 8'hA0 : 8'h10) + 8'(m_loaded[k]);
      if (stall_at >= 0 && m_drained[k] == stall_at && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      start_v[k] = 1'b0;
      if (busy_starts && m_active[k] && m_cleared[k] && m_loaded[k] == 10) start_v[k] = 1'b1;
      if (busy_starts && m_active[k] && m_run[k] >= run_len(k) && m_drained[k] == 20) start_v[k] = 1'b1;
      if (chain && m_drained[k] >= 60) start_v[k] = 1'b1;
      @(posedge clk); #2;
      n++;
    end
    start_v[k] = 1'b0;
    in_valid   = 1'b0;
    if (!done_seen[k]) checkOutput("block_timeout", k, 0, 1);
  endtask

  initial begin
    int saved_done;
    int n;
    rst = 1'b1; start_v = 2'b11; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

    // Reset for two edges with start pulsing underneath it.
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0; start_v = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_in_ready", k, in_ready_v[k], 0);
      checkOutput("rst_out_valid", k, out_valid_v[k], 0);
      checkOutput("rst_busy", k, busy_v[k], 0);
      checkOutput("rst_done", k, done_v[k], 0);
      checkOutput("rst_clear", k, core_clear_v[k], 0);
      checkOutput("rst_hold", k, core_hold_v[k], 1);
      checkOutput("rst_diag", k, core_diag_v[k], 0);
      checkOutput("rst_write", k, core_write_v[k], 0);
      checkOutput("rst_addr", k, core_addr_v[k], 0);
    end
    @(posedge clk); #2;

    // Full-rate block on the default configuration.
    applyStimulus(0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    checkOutput("full_first_wr_rel", 0, first_wr_rel[0], 2);
    checkOutput("full_first_wr_addr", 0, first_wr_addr[0], 16);
    checkOutput("full_writes", 0, wr_cnt[0], 48);
    checkOutput("full_run_rel", 0, run_rel[0], 50);
    checkOutput("full_run_len", 0, run_cnt[0], 20);
    checkOutput("full_diag", 0, diag_vec[0], 12'b0101_0101_0101);
    checkOutput("full_out_rel", 0, ov_rel[0], 70);
    checkOutput("full_handshakes", 0, hs_cnt[0], 64);
    checkOutput("full_done_rel", 0, done_rel[0], 134);

    // Backpressure: 1010 valid on load, 5-cycle stall at read address 7.
    applyStimulus(0, 1'b1, 1'b1, 7, 1'b0, 1'b0);
    checkOutput("bp_writes", 0, wr_cnt[0], 48);
    checkOutput("bp_handshakes", 0, hs_cnt[0], 64);
    checkOutput("bp_stall_cycles", 0, stall_cnt[0], 5);

    // Short configuration: 4 rounds of 3 cycles each.
    applyStimulus(1, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    checkOutput("s3_run_len", 1, run_cnt[1], 12);
    checkOutput("s3_diag", 1, diag_vec[1], 12'b000111000111);
    checkOutput("s3_done_rel", 1, done_rel[1], 126);

    // Reset in the middle of RUN at step 5, then a fresh block.
    start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0;
    n = 0;
    while (m_run[0] != 5 && n < 200) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(m_loaded[0]);
      @(posedge clk); #2;
      n++;
    end
    if (m_run[0] != 5) checkOutput("midrun_timeout", 0, 0, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrun_hold_after_rst", 0, core_hold_v[0], 1);
    checkOutput("midrun_busy_after_rst", 0, busy_v[0], 0);
    @(posedge clk); #2;
    applyStimulus(0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    checkOutput("restart_clear_rel", 0, clear_abs[0] - start_cyc[0], 1);
    checkOutput("restart_first_addr", 0, first_wr_addr[0], 16);
    checkOutput("restart_done_rel", 0, done_rel[0], 134);

    // Starts while busy are ignored; a start alongside done is taken.
    applyStimulus(0, 1'b1, 1'b0, -1, 1'b1, 1'b1);
    checkOutput("busy_start_done_rel", 0, done_rel[0], 134);
    saved_done = done_abs[0];
    applyStimulus(0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    checkOutput("chain_clear_gap", 0, clear_abs[0] - saved_done, 1);
    checkOutput("chain_done_rel", 0, done_rel[0], 134);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
